ebs_watchdog: RTL and testbench

- Heartbeat supervisor that generates the `Watchdog` health signal consumed by the shutdown-circuit (SDC) logic.
- Monitors a toggling heartbeat from the autonomous-system computer.
- Watchdog is asserted only after a stable heartbeat has been proven.
- Deasserts and latches a fault on a missing heartbeat (timeout) or an over-fast heartbeat (stuck oscillation).
- Fault release requires an explicit clear outside autonomous driving mode.

---
 rtl/ebs_watchdog_if.sv | 13 +
 rtl/ebs_watchdog.sv | 76 +++++++
 tb/tb_ebs_watchdog.sv | 119 +++++++++++
 3 files changed

// File: rtl/ebs_watchdog_if.sv
// ebs_watchdog_if: heartbeat inputs and health outputs of the SDC watchdog
interface ebs_watchdog_if;
    logic       Heartbeat;
    logic       Watchdog_clear;
    logic       AS_driving_mode;
    logic       Watchdog;
    logic [1:0] Watchdog_state;
    logic [1:0] Fault_code;
    modport master (output Heartbeat, Watchdog_clear, AS_driving_mode,
                    input  Watchdog, Watchdog_state, Fault_code);
    modport slave  (input  Heartbeat, Watchdog_clear, AS_driving_mode,
                    output Watchdog, Watchdog_state, Fault_code);
endinterface

// File: rtl/ebs_watchdog.sv
// ebs_watchdog: heartbeat supervisor driving the SDC Watchdog health signal
module ebs_watchdog #(
    parameter int TIMEOUT_CYCLES    = 500000,
    parameter int MIN_PERIOD_CYCLES = 5000,
    parameter int ARM_EDGES         = 4,
    parameter int CNT_W             = 20
) (
    input logic          clk,
    input logic          Power_on_Reset_n,
    ebs_watchdog_if.slave wd
);
    localparam int E_W = $clog2(ARM_EDGES + 1);
    typedef enum logic [1:0] {IDLE, ARMING, OK, TRIPPED} state_t;
    state_t           state;
    logic [1:0]       sync;
    logic             prev;
    logic             wd_q;
    logic [1:0]       fault;
    logic [CNT_W-1:0] cnt;
    logic [E_W-1:0]   ecnt;
    logic [E_W-1:0]   ecnt_inc;
    logic             hb_edge;
    logic             too_fast;
    logic             timeout;
    assign hb_edge  = sync[1] ^ prev;
    assign ecnt_inc = ecnt + 1'b1;
    // The interval seen by an edge is cnt+1: the counter's would-be value this cycle
    assign too_fast = cnt < CNT_W'(MIN_PERIOD_CYCLES - 1);
    assign timeout  = cnt >= CNT_W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge Power_on_Reset_n) begin
        if (!Power_on_Reset_n) begin
            sync  <= '0;
            prev  <= 1'b0;
            cnt   <= '0;
            ecnt  <= '0;
            state <= IDLE;
            wd_q  <= 1'b0;
            fault <= 2'b00;
        end else begin
            sync <= {sync[0], wd.Heartbeat};
            prev <= sync[1];
            cnt  <= hb_edge ? '0 : (cnt == CNT_W'(TIMEOUT_CYCLES) ? cnt : cnt + 1'b1);
            case (state)
                IDLE: if (hb_edge) begin
                    state <= ARMING;
                    ecnt  <= E_W'(1);
                end
                ARMING, OK: if (hb_edge && too_fast) begin
                    state <= TRIPPED;
                    fault <= 2'b10;
                    wd_q  <= 1'b0;
                end else if (hb_edge && state == ARMING) begin
                    ecnt <= ecnt_inc;
                    if (ecnt_inc == E_W'(ARM_EDGES)) begin
                        state <= OK;
                        wd_q  <= 1'b1;
                    end
                end else if (!hb_edge && timeout) begin
                    state <= TRIPPED;
                    fault <= 2'b01;
                    wd_q  <= 1'b0;
                end
                TRIPPED: if (wd.Watchdog_clear && !wd.AS_driving_mode) begin
                    state <= IDLE;
                    fault <= 2'b00;
                    cnt   <= '0;
                    ecnt  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign wd.Watchdog       = wd_q;
    assign wd.Watchdog_state = state;
    assign wd.Fault_code     = fault;
endmodule

// File: tb/tb_ebs_watchdog.sv
// tb_ebs_watchdog: directed checks of arming, faults, clear gating and reset
module tb_ebs_watchdog;
    logic clk = 1'b0;
    logic Power_on_Reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    ebs_watchdog_if bus ();
    ebs_watchdog #(.TIMEOUT_CYCLES(100), .MIN_PERIOD_CYCLES(10), .ARM_EDGES(4), .CNT_W(20)) dut (
        .clk(clk),
        .Power_on_Reset_n(Power_on_Reset_n),
        .wd(bus)
    );
    always #5 clk = ~clk;
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_out(input string tag, input logic [1:0] st, input logic w, input logic [1:0] f);
        chk({tag, "_state"}, {2'b00, bus.Watchdog_state}, {2'b00, st});
        chk({tag, "_wd"},    {3'b000, bus.Watchdog},      {3'b000, w});
        chk({tag, "_fault"}, {2'b00, bus.Fault_code},     {2'b00, f});
    endtask
    task automatic toggle();
        bus.Heartbeat = ~bus.Heartbeat;
    endtask
    // Four edges spaced by gap cycles; ends 3 cycles after the last toggle
    task automatic arm(input string tag, input int gap);
        toggle();
        cyc(2);
        chk_out({tag, "_pre"}, 2'b00, 1'b0, 2'b00);
        cyc(1);
        chk_out({tag, "_e1"}, 2'b01, 1'b0, 2'b00);
        for (int i = 2; i <= 4; i++) begin
            cyc(gap - 3);
            toggle();
            cyc(2);
            chk_out($sformatf("%s_e%0d_pre", tag, i), 2'b01, 1'b0, 2'b00);
            cyc(1);
            chk_out($sformatf("%s_e%0d", tag, i), i == 4 ? 2'b10 : 2'b01, i == 4, 2'b00);
        end
    endtask
    initial begin
        bus.Heartbeat       = 1'b0;
        bus.Watchdog_clear  = 1'b0;
        bus.AS_driving_mode = 1'b0;
        cyc(3);
        chk_out("reset", 2'b00, 1'b0, 2'b00);
        Power_on_Reset_n = 1'b1;
        cyc(5);
        chk_out("idle", 2'b00, 1'b0, 2'b00);
        arm("arm", 50);
        // Clear outside TRIPPED has no effect
        bus.Watchdog_clear = 1'b1;
        cyc(1);
        bus.Watchdog_clear = 1'b0;
        chk_out("clr_in_ok", 2'b10, 1'b1, 2'b00);
        cyc(6);
        toggle();
        cyc(10);
        toggle();
        cyc(3);
        chk_out("min_exact", 2'b10, 1'b1, 2'b00);
        cyc(97);
        toggle();
        cyc(3);
        chk_out("tmo_exact", 2'b10, 1'b1, 2'b00);
        cyc(99);
        chk_out("tmo_pre", 2'b10, 1'b1, 2'b00);
        cyc(1);
        chk_out("timeout", 2'b11, 1'b0, 2'b01);
        toggle();
        cyc(5);
        chk_out("tripped_edge", 2'b11, 1'b0, 2'b01);
        bus.AS_driving_mode = 1'b1;
        bus.Watchdog_clear  = 1'b1;
        cyc(1);
        bus.Watchdog_clear  = 1'b0;
        chk_out("clr_as", 2'b11, 1'b0, 2'b01);
        bus.AS_driving_mode = 1'b0;
        bus.Watchdog_clear  = 1'b1;
        cyc(1);
        bus.Watchdog_clear  = 1'b0;
        chk_out("clr", 2'b00, 1'b0, 2'b00);
        cyc(5);
        arm("rearm", 20);
        cyc(17);
        toggle();
        cyc(5);
        toggle();
        cyc(2);
        chk_out("fast_pre", 2'b10, 1'b1, 2'b00);
        cyc(1);
        chk_out("too_fast", 2'b11, 1'b0, 2'b10);
        cyc(150);
        chk_out("fast_held", 2'b11, 1'b0, 2'b10);
        bus.Watchdog_clear = 1'b1;
        cyc(1);
        bus.Watchdog_clear = 1'b0;
        chk_out("clr2", 2'b00, 1'b0, 2'b00);
        cyc(5);
        arm("arm3", 30);
        cyc(5);
        #2 Power_on_Reset_n = 1'b0;
        #1 chk_out("async_rst", 2'b00, 1'b0, 2'b00);
        cyc(2);
        chk_out("rst_hold", 2'b00, 1'b0, 2'b00);
        Power_on_Reset_n = 1'b1;
        cyc(5);
        arm("post_rst", 15);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
